// File: rtl/snn_grid_sequencer.sv
// snn_grid_sequencer
// Timestep sequencer for one SNN neuron grid. A tick starts one timestep:
// latch scheduler spikes, sweep every axon, optionally leak, update the
// potentials, then emit one spike slot per neuron into the local output
// buffers while they are not full.
// The sequencer also queues one early tick, counts overruns and keeps a
// clearable sticky error flag.
//
// Build option:
//   SNN_LEAK_EN - when defined, a one-cycle LEAK state sits between
//                 SPIKE_IN and UPDATE. When undefined, `leak` is tied
//                 low and encoding 8 decodes as IDLE.
//
// The FSM state is visible on grid_state for checkers and debug.

module snn_grid_sequencer #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int QUEUE_TICK  = 1,
  localparam int AW = (NUM_AXONS   > 2) ? $clog2(NUM_AXONS)   : 1,
  localparam int NW = (NUM_NEURONS > 2) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          local_buffers_full,
  input  logic          err_clr,
  output logic [AW-1:0] axon_num,
  output logic [NW-1:0] neuron_num,
  output logic          scheduler_set,
  output logic          new_neuron,
  output logic          process_spike,
  output logic          leak,
  output logic          update_potential,
  output logic          shot,
  output logic          scheduler_clr,
  output logic          done,
  output logic          error,
  output logic [7:0]    overrun_cnt,
  output logic          tick_pending,
  output logic [3:0]    grid_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_DATA = 4'd1,
    S_INITIAL  = 4'd2,
    S_SPIKE_IN = 4'd3,
    S_UPDATE   = 4'd4,
    S_PRE_SHOT = 4'd5,
    S_SHOT     = 4'd6,
    S_LAST     = 4'd7,
    S_LEAK     = 4'd8
  } state_t;

  state_t state;
  state_t state_next;

  logic axon_last;
  logic neuron_last;
  logic shot_accept;
  logic busy;
  logic tick_overrun;
  logic tick_queue;
  logic overrun_err;

  // Output-buffer handshake: in SHOT the sequencer offers one neuron per
  // cycle (shot=1 acts as valid). The buffers take it in any cycle where
  // local_buffers_full is low (ready). While full is high, the offer stays
  // unchanged: same neuron_num, same state.
  assign shot_accept = (state == S_SHOT) && !local_buffers_full;

  assign axon_last   = (axon_num   == AW'(NUM_AXONS - 1));
  assign neuron_last = (neuron_num == NW'(NUM_NEURONS - 1));

  // A tick is an overrun when the grid is busy (LAST included) or when a
  // queued tick is already waiting in IDLE. The first busy tick is queued
  // if queueing is enabled and the single queue slot is free.
  assign busy         = (state != S_IDLE);
  assign tick_overrun = tick && (busy || tick_pending);
  assign tick_queue   = tick_overrun && (QUEUE_TICK != 0) && busy && !tick_pending;
  assign overrun_err  = tick_overrun && !tick_queue;

  assign grid_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_next       = S_IDLE;
    scheduler_set    = 1'b0;
    new_neuron       = 1'b0;
    process_spike    = 1'b0;
    leak             = 1'b0;
    update_potential = 1'b0;
    shot             = 1'b0;
    scheduler_clr    = 1'b0;
    done             = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick || tick_pending) state_next = S_GET_DATA;
        else                      state_next = S_IDLE;
      end
      S_GET_DATA: begin
        scheduler_set = 1'b1;
        new_neuron    = 1'b1;
        state_next    = S_INITIAL;
      end
      S_INITIAL: begin
        state_next = S_SPIKE_IN;
      end
      S_SPIKE_IN: begin
        process_spike = 1'b1;
        if (axon_last) begin
`ifdef SNN_LEAK_EN
          state_next = S_LEAK;
`else
          state_next = S_UPDATE;
`endif
        end else begin
          state_next = S_SPIKE_IN;
        end
      end
`ifdef SNN_LEAK_EN
      S_LEAK: begin
        leak       = 1'b1;
        state_next = S_UPDATE;
      end
`endif
      S_UPDATE: begin
        update_potential = 1'b1;
        state_next       = S_PRE_SHOT;
      end
      S_PRE_SHOT: begin
        state_next = S_SHOT;
      end
      S_SHOT: begin
        shot = 1'b1;
        if (shot_accept && neuron_last) state_next = S_LAST;
        else                            state_next = S_SHOT;
      end
      S_LAST: begin
        scheduler_clr = 1'b1;
        done          = 1'b1;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Axon index: cleared when a timestep starts, stepped through the sweep,
  // and held on the final axon.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      axon_num <= '0;
    end else if (state == S_GET_DATA) begin
      axon_num <= '0;
    end else if ((state == S_SPIKE_IN) && !axon_last) begin
      axon_num <= axon_num + AW'(1);
    end
  end

  // Neuron index: cleared before integration and again before the shot
  // sweep, then advanced only on an accepted shot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      neuron_num <= '0;
    end else if ((state == S_INITIAL) || (state == S_PRE_SHOT)) begin
      neuron_num <= '0;
    end else if (shot_accept && !neuron_last) begin
      neuron_num <= neuron_num + NW'(1);
    end
  end

  // Single-entry tick queue. It fills on the first busy tick and drains
  // when the queued timestep enters GET_DATA.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_pending <= 1'b0;
    end else if (tick_queue) begin
      tick_pending <= 1'b1;
    end else if (state == S_GET_DATA) begin
      tick_pending <= 1'b0;
    end
  end

  // Sticky error and saturating overrun count. An overrun in the same
  // cycle as err_clr wins, so the event that caused it is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error       <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (overrun_err) begin
      error <= 1'b1;
      if (err_clr) begin
        overrun_cnt <= 8'd1;
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end else if (err_clr) begin
      error       <= 1'b0;
      overrun_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_snn_grid_sequencer.sv
// tb_snn_grid_sequencer
// Directed bench for snn_grid_sequencer with NUM_AXONS=4, NUM_NEURONS=4,
// QUEUE_TICK=1. The expected leak behaviour follows SNN_LEAK_EN.

module tb_snn_grid_sequencer;

  localparam int NA = 4;
  localparam int NN = 4;
`ifdef SNN_LEAK_EN
  localparam int LEAK_X = 1;
`else
  localparam int LEAK_X = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       local_buffers_full;
  logic       err_clr;
  logic [1:0] axon_num;
  logic [1:0] neuron_num;
  logic       scheduler_set, new_neuron, process_spike, leak;
  logic       update_potential, shot, scheduler_clr, done;
  logic       error;
  logic [7:0] overrun_cnt;
  logic       tick_pending;
  logic [3:0] grid_state;

  int tests;
  int fails;
  logic [7:0] exp_q[$];

  snn_grid_sequencer #(
    .NUM_AXONS  (NA),
    .NUM_NEURONS(NN),
    .QUEUE_TICK (1)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .tick              (tick),
    .local_buffers_full(local_buffers_full),
    .err_clr           (err_clr),
    .axon_num          (axon_num),
    .neuron_num        (neuron_num),
    .scheduler_set     (scheduler_set),
    .new_neuron        (new_neuron),
    .process_spike     (process_spike),
    .leak              (leak),
    .update_potential  (update_potential),
    .shot              (shot),
    .scheduler_clr     (scheduler_clr),
    .done              (done),
    .error             (error),
    .overrun_cnt       (overrun_cnt),
    .tick_pending      (tick_pending),
    .grid_state        (grid_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and sample 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_idle_clear(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (grid_state == 4'd0 && !tick_pending) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick = 1'b0; local_buffers_full = 1'b0; err_clr = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    tests++; if (grid_state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", grid_state); end
    tests++; if (axon_num !== 2'd0) begin fails++; $display("FAIL reset_axon: got %0d expected 0", axon_num); end
    tests++; if (neuron_num !== 2'd0) begin fails++; $display("FAIL reset_neuron: got %0d expected 0", neuron_num); end
    tests++; if (error !== 1'b0 || overrun_cnt !== 8'd0) begin fails++; $display("FAIL reset_err: got error=%0b cnt=%0d expected 0/0", error, overrun_cnt); end
    tests++; if (tick_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %0b expected 0", tick_pending); end
    tests++;
    if ({scheduler_set, new_neuron, process_spike, leak, update_potential, shot, scheduler_clr, done} !== 8'd0) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {scheduler_set, new_neuron, process_spike, leak, update_potential, shot, scheduler_clr, done});
    end
  endtask

  task automatic test_single_tick();
    logic [3:0] st_q[$];
    logic [3:0] exp_s;
    logic [7:0] exp_a;
    int done_cyc, shot_n, leak_n;
    st_q = {}; exp_q = {};
    st_q.push_back(4'd1); st_q.push_back(4'd2);
    for (int i = 0; i < NA; i++) begin
      st_q.push_back(4'd3);
      exp_q.push_back(8'(i));
    end
    if (LEAK_X == 1) st_q.push_back(4'd8);
    st_q.push_back(4'd4); st_q.push_back(4'd5);
    for (int i = 0; i < NN; i++) st_q.push_back(4'd6);
    st_q.push_back(4'd7);
    tick = 1'b1; step(); tick = 1'b0;
    tests++; if ({scheduler_set, new_neuron} !== 2'b11) begin fails++; $display("FAIL get_data_strobes: got %b expected 11", {scheduler_set, new_neuron}); end
    done_cyc = 0; shot_n = 0; leak_n = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      exp_s = (st_q.size() > 0) ? st_q.pop_front() : 4'd0;
      tests++; if (grid_state !== exp_s) begin fails++; $display("FAIL state_seq cyc %0d: got %0d expected %0d", cyc, grid_state, exp_s); end
      if (process_spike) begin
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        tests++; if (8'(axon_num) !== exp_a) begin fails++; $display("FAIL spike_axon: got %0d expected %0d", axon_num, exp_a); end
      end
      if (shot) shot_n++;
      if (leak) leak_n++;
      if (done) begin
        done_cyc = cyc;
        tests++; if (scheduler_clr !== 1'b1) begin fails++; $display("FAIL last_clr: got %0b expected 1", scheduler_clr); end
        break;
      end
      step();
    end
    tests++; if (done_cyc != 13 + LEAK_X) begin fails++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, 13 + LEAK_X); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL spike_count: got %0d left expected 0", exp_q.size()); end
    tests++; if (shot_n != NN) begin fails++; $display("FAIL shot_count: got %0d expected %0d", shot_n, NN); end
    tests++; if (leak_n != LEAK_X) begin fails++; $display("FAIL leak_count: got %0d expected %0d", leak_n, LEAK_X); end
    step();
    tests++; if (grid_state !== 4'd0 || done !== 1'b0) begin fails++; $display("FAIL after_last: got state=%0d done=%0b expected 0/0", grid_state, done); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_n;
    int done_cyc, shot_n, n2, stall_left;
    exp_q = {};
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'd2);
    exp_q.push_back(8'd3);
    tick = 1'b1; step(); tick = 1'b0;
    done_cyc = 0; shot_n = 0; n2 = 0; stall_left = 3;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (shot) begin
        shot_n++;
        if (neuron_num == 2'd2) n2++;
        exp_n = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        tests++; if (8'(neuron_num) !== exp_n) begin fails++; $display("FAIL bp_neuron: got %0d expected %0d", neuron_num, exp_n); end
      end
      if (done) begin done_cyc = cyc; break; end
      if (shot && neuron_num == 2'd2 && stall_left > 0) begin
        local_buffers_full = 1'b1;
        stall_left--;
      end else begin
        local_buffers_full = 1'b0;
      end
      step();
    end
    local_buffers_full = 1'b0;
    tests++; if (n2 != 4) begin fails++; $display("FAIL bp_hold: got %0d cycles at neuron 2 expected 4", n2); end
    tests++; if (shot_n != NN + 3) begin fails++; $display("FAIL bp_shots: got %0d expected %0d", shot_n, NN + 3); end
    tests++; if (done_cyc != 16 + LEAK_X) begin fails++; $display("FAIL bp_done_cycle: got %0d expected %0d", done_cyc, 16 + LEAK_X); end
    step();
  endtask

  task automatic test_tick_queue();
    bit ok;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    tests++; if (tick_pending !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL queue_first: got pending=%0b error=%0b expected 1/0", tick_pending, error); end
    step();
    tick = 1'b1; step(); tick = 1'b0;
    tests++; if (error !== 1'b1 || overrun_cnt !== 8'd1) begin fails++; $display("FAIL queue_second: got error=%0b cnt=%0d expected 1/1", error, overrun_cnt); end
    wait_done(40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL queue_done_timeout: got no done expected done"); end
    step();
    tests++; if (grid_state !== 4'd0 || tick_pending !== 1'b1) begin fails++; $display("FAIL queue_idle: got state=%0d pending=%0b expected 0/1", grid_state, tick_pending); end
    step();
    tests++; if (grid_state !== 4'd1) begin fails++; $display("FAIL queue_restart: got state=%0d expected 1", grid_state); end
    step();
    tests++; if (tick_pending !== 1'b0 || grid_state !== 4'd2) begin fails++; $display("FAIL queue_drain: got pending=%0b state=%0d expected 0/2", tick_pending, grid_state); end
    wait_done(40, ok);
    step(); step(); step();
    tests++; if (!ok || grid_state !== 4'd0) begin fails++; $display("FAIL queue_settle: got ok=%0b state=%0d expected 1/0", ok, grid_state); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    tests++; if (error !== 1'b0 || overrun_cnt !== 8'd0) begin fails++; $display("FAIL queue_clear: got error=%0b cnt=%0d expected 0/0", error, overrun_cnt); end
  endtask

  task automatic test_overrun_saturate();
    bit ok;
    int drops;
    logic [7:0] prev;
    drops = 0;
    tick = 1'b1;
    for (int i = 0; i < 400; i++) begin
      prev = overrun_cnt;
      step();
      if (overrun_cnt < prev) drops++;
    end
    tick = 1'b0;
    tests++; if (overrun_cnt !== 8'd255 || error !== 1'b1) begin fails++; $display("FAIL sat_count: got cnt=%0d error=%0b expected 255/1", overrun_cnt, error); end
    tests++; if (drops != 0) begin fails++; $display("FAIL sat_monotonic: got %0d decreases expected 0", drops); end
    wait_idle_clear(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL sat_drain_timeout: got busy expected idle"); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    tests++; if (error !== 1'b0 || overrun_cnt !== 8'd0) begin fails++; $display("FAIL sat_clear: got error=%0b cnt=%0d expected 0/0", error, overrun_cnt); end
    tick = 1'b1; step();
    step();
    tests++; if (tick_pending !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL coinc_queue: got pending=%0b error=%0b expected 1/0", tick_pending, error); end
    step();
    step();
    tests++; if (overrun_cnt !== 8'd2) begin fails++; $display("FAIL coinc_pre: got cnt=%0d expected 2", overrun_cnt); end
    err_clr = 1'b1; step();
    tick = 1'b0; err_clr = 1'b0;
    tests++; if (error !== 1'b1 || overrun_cnt !== 8'd1) begin fails++; $display("FAIL coinc_clear: got error=%0b cnt=%0d expected 1/1", error, overrun_cnt); end
    wait_idle_clear(100, ok);
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int done_n;
    tick = 1'b1; step(); step(); tick = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (grid_state == 4'd6) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok || tick_pending !== 1'b1) begin fails++; $display("FAIL mid_reach_shot: got ok=%0b pending=%0b expected 1/1", ok, tick_pending); end
    reset_n = 1'b0; step();
    tests++;
    if (grid_state !== 4'd0 || axon_num !== 2'd0 || neuron_num !== 2'd0 || tick_pending !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got state=%0d axon=%0d neuron=%0d pending=%0b done=%0b expected 0/0/0/0/0",
               grid_state, axon_num, neuron_num, tick_pending, done);
    end
    reset_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || grid_state != 4'd0) done_n++;
    end
    tests++; if (done_n != 0) begin fails++; $display("FAIL mid_no_restart: got %0d busy cycles expected 0", done_n); end
  endtask

  // Scenario sequence and final report
  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; tick = 1'b0; local_buffers_full = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single_tick();
    test_backpressure();
    test_tick_queue();
    test_overrun_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
